// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC register with redirect/halt/fault sequencing, pipeline
// enable/flush control and saturating redirect/stall counters.
module pc_redirect_ctrl #(
  parameter int WIDTH = 9,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             pc_sel,
  input  logic [31:0]      branch_pc,
  input  logic             halt,
  input  logic             load_use,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;
  state_t state, state_nx;
  logic run, legal, ex_ctl, do_halt, do_redir, do_fault, do_stall, do_adv;
  assign run      = state == RUN;
  assign legal    = branch_pc[1:0] == 2'b00 && (branch_pc >> WIDTH) == 32'd0;
  // halt and pc_sel only count when EX holds a real instruction
  assign ex_ctl   = ex_valid & (halt | pc_sel);
  assign do_halt  = run & ex_valid & halt;
  assign do_redir = run & ex_valid & ~halt & pc_sel & legal;
  assign do_fault = run & ex_valid & ~halt & pc_sel & ~legal;
  assign do_stall = run & ~ex_ctl & load_use;
  assign do_adv   = run & ~ex_ctl & ~load_use;
  assign if_id_en    = do_redir | do_adv;
  assign if_id_flush = (state == FAULT) | do_halt | do_redir | do_fault;
  assign id_ex_flush = ~do_adv;
  always_comb begin
    state_nx = do_halt ? HALTED : do_fault ? FAULT : (state == HALTED && resume) ? RUN : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      halted       <= 1'b0;
      fault        <= 1'b0;
      pc           <= RESET_PC;
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      state  <= state_nx;
      halted <= state_nx == HALTED;
      fault  <= state_nx == FAULT;
      pc     <= do_redir ? branch_pc[WIDTH-1:0] : do_adv ? pc + WIDTH'(4) : pc;
      if (do_redir && redirect_cnt != '1) redirect_cnt <= redirect_cnt + CNT_W'(1);
      if (do_stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed scenarios plus randomized run against a behavioural model.
module tb_pc_redirect_ctrl;
  logic clk, rst_n, ex_valid, pc_sel, halt, load_use, resume;
  logic [31:0] branch_pc;
  logic [8:0] pc;
  logic if_id_en, if_id_flush, id_ex_flush, halted, fault;
  logic [15:0] redirect_cnt, stall_cnt;
  int checks = 0;
  int errors = 0;

  pc_redirect_ctrl #(.WIDTH(9), .RESET_PC(9'd0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .pc_sel(pc_sel), .branch_pc(branch_pc),
    .halt(halt), .load_use(load_use), .resume(resume), .pc(pc), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .halted(halted), .fault(fault),
    .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic set_in(input logic ev, input logic ps, input logic [31:0] bpc,
                        input logic h, input logic lu, input logic rs);
    ex_valid = ev; pc_sel = ps; branch_pc = bpc; halt = h; load_use = lu; resume = rs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    set_in(0, 0, 0, 0, 0, 0);
    rst_n = 0;
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_in(0, 0, 0, 0, 0, 0);
    checks++;
    if ({pc, halted, fault, redirect_cnt, stall_cnt} !== '0) begin
      errors++; $display("FAIL reset_state pc=%h h=%b f=%b rc=%h sc=%h want all 0", pc, halted, fault, redirect_cnt, stall_cnt);
    end
    checks++;
    if ({if_id_en, if_id_flush, id_ex_flush} !== 3'b100) begin
      errors++; $display("FAIL reset_ctl got %b want 100", {if_id_en, if_id_flush, id_ex_flush});
    end
    rst_n = 1;
  endtask

  task automatic test_sequential();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pc !== 9'(4 * i) || {if_id_en, if_id_flush, id_ex_flush} !== 3'b100) begin
        errors++; $display("FAIL seq_%0d pc=%h ctl=%b want pc=%h ctl=100", i, pc, {if_id_en, if_id_flush, id_ex_flush}, 4 * i);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    repeat (4) tick();
    set_in(1, 1, 32'h40, 0, 0, 0);
    checks++;
    if (pc !== 9'h010 || {if_id_en, if_id_flush, id_ex_flush} !== 3'b111) begin
      errors++; $display("FAIL redir_same pc=%h ctl=%b want 010 111", pc, {if_id_en, if_id_flush, id_ex_flush});
    end
    tick();
    set_in(1, 1, 32'h80, 0, 1, 0);
    checks++;
    if (pc !== 9'h040 || redirect_cnt !== 16'd1) begin
      errors++; $display("FAIL redir_next pc=%h rc=%0d want 040 1", pc, redirect_cnt);
    end
    checks++;
    if ({if_id_en, if_id_flush, id_ex_flush} !== 3'b111) begin
      errors++; $display("FAIL redir_lu_ctl got %b want 111", {if_id_en, if_id_flush, id_ex_flush});
    end
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++;
    if (pc !== 9'h080 || redirect_cnt !== 16'd2 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL redir_lu pc=%h rc=%0d sc=%0d want 080 2 0", pc, redirect_cnt, stall_cnt);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    repeat (8) tick();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 1, 0);
      checks++;
      if (pc !== 9'h020 || {if_id_en, if_id_flush, id_ex_flush} !== 3'b001) begin
        errors++; $display("FAIL stall_%0d pc=%h ctl=%b want 020 001", i, pc, {if_id_en, if_id_flush, id_ex_flush});
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0);
    checks++;
    if (pc !== 9'h020 || stall_cnt !== 16'd2) begin
      errors++; $display("FAIL stall_end pc=%h sc=%0d want 020 2", pc, stall_cnt);
    end
    tick();
    checks++;
    if (pc !== 9'h024) begin
      errors++; $display("FAIL stall_resume pc=%h want 024", pc);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    tick();
    set_in(1, 1, 32'h40, 1, 0, 0);
    checks++;
    if ({if_id_en, if_id_flush, id_ex_flush, halted} !== 4'b0110) begin
      errors++; $display("FAIL halt_same got %b want 0110", {if_id_en, if_id_flush, id_ex_flush, halted});
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      set_in(1, i[0], 32'h40, 0, i[1], 0);
      checks++;
      if (pc !== 9'h004 || {halted, if_id_en, if_id_flush, id_ex_flush} !== 4'b1001 || redirect_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
        errors++; $display("FAIL halted_%0d pc=%h st=%b rc=%0d sc=%0d want 004 1001 0 0", i, pc, {halted, if_id_en, if_id_flush, id_ex_flush}, redirect_cnt, stall_cnt);
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 1);
    checks++;
    if ({halted, if_id_en, if_id_flush, id_ex_flush} !== 4'b1001) begin
      errors++; $display("FAIL resume_cycle got %b want 1001", {halted, if_id_en, if_id_flush, id_ex_flush});
    end
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++;
    if (pc !== 9'h004 || halted !== 1'b0 || if_id_en !== 1'b1) begin
      errors++; $display("FAIL resumed pc=%h h=%b en=%b want 004 0 1", pc, halted, if_id_en);
    end
    tick();
    checks++;
    if (pc !== 9'h008) begin
      errors++; $display("FAIL resume_adv pc=%h want 008", pc);
    end
  endtask

  task automatic test_fault();
    logic [31:0] bad [2];
    bad[0] = 32'h42;
    bad[1] = 32'h200;
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      tick();
      set_in(1, 1, bad[k], 0, 0, 0);
      checks++;
      if ({if_id_en, if_id_flush, id_ex_flush, fault} !== 4'b0110) begin
        errors++; $display("FAIL fault_same_%0d got %b want 0110", k, {if_id_en, if_id_flush, id_ex_flush, fault});
      end
      tick();
      set_in(0, 0, 0, 0, 0, 1);
      checks++;
      if (pc !== 9'h004 || fault !== 1'b1 || redirect_cnt !== 16'd0 || {if_id_en, if_id_flush, id_ex_flush} !== 3'b011) begin
        errors++; $display("FAIL fault_%0d pc=%h f=%b rc=%0d ctl=%b want 004 1 0 011", k, pc, fault, redirect_cnt, {if_id_en, if_id_flush, id_ex_flush});
      end
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      checks++;
      if (pc !== 9'h004 || fault !== 1'b1) begin
        errors++; $display("FAIL fault_resume_%0d pc=%h f=%b want 004 1", k, pc, fault);
      end
      rst_n = 0;
      #1;
      checks++;
      if (pc !== 9'h000 || fault !== 1'b0 || if_id_en !== 1'b1) begin
        errors++; $display("FAIL fault_reset_%0d pc=%h f=%b en=%b want 000 0 1", k, pc, fault, if_id_en);
      end
      rst_n = 1;
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    set_in(1, 1, 32'h1FC, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (pc !== 9'h000) begin
      errors++; $display("FAIL wrap pc=%h want 000", pc);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    set_in(1, 1, 32'h40, 0, 0, 0);
    repeat (65534) tick();
    checks++;
    if (redirect_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL sat_pre rc=%h want FFFE", redirect_cnt);
    end
    repeat (6) tick();
    checks++;
    if (redirect_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat rc=%h want FFFF", redirect_cnt);
    end
  endtask

  task automatic test_random();
    int mode, m_pc, m_rc, m_sc, nxt;
    logic ev, ps, h, lu, rs;
    logic [31:0] bpc;
    logic [2:0] ctl;
    apply_reset();
    mode = 0; m_pc = 0; m_rc = 0; m_sc = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        apply_reset();
        mode = 0; m_pc = 0; m_rc = 0; m_sc = 0;
      end
      ev = $urandom_range(0, 3) != 0;
      ps = $urandom_range(0, 2) == 0;
      h = $urandom_range(0, 15) == 0;
      lu = $urandom_range(0, 3) == 0;
      rs = $urandom_range(0, 5) == 0;
      bpc = $urandom_range(0, 9) == 0 ? $urandom : 32'($urandom_range(0, 127) * 4);
      set_in(ev, ps, bpc, h, lu, rs);
      nxt = mode;
      if (mode == 1) begin
        ctl = 3'b001;
        if (rs) nxt = 0;
      end else if (mode == 2) ctl = 3'b011;
      else if (ev && h) begin
        ctl = 3'b011; nxt = 1;
      end else if (ev && ps && bpc % 4 == 0 && bpc < 32'd512) begin
        ctl = 3'b111; m_pc = int'(bpc);
        if (m_rc < 65535) m_rc++;
      end else if (ev && ps) begin
        ctl = 3'b011; nxt = 2;
      end else if (lu) begin
        ctl = 3'b001;
        if (m_sc < 65535) m_sc++;
      end else begin
        ctl = 3'b100; m_pc = (m_pc + 4) % 512;
      end
      checks++;
      if ({if_id_en, if_id_flush, id_ex_flush} !== ctl || halted !== (mode == 1) || fault !== (mode == 2)) begin
        errors++; $display("FAIL rand_ctl_%0d ctl=%b h=%b f=%b want ctl=%b mode=%0d", c, {if_id_en, if_id_flush, id_ex_flush}, halted, fault, ctl, mode);
      end
      tick();
      mode = nxt;
      checks++;
      if (pc !== 9'(m_pc) || redirect_cnt !== 16'(m_rc) || stall_cnt !== 16'(m_sc)) begin
        errors++; $display("FAIL rand_state_%0d pc=%h rc=%0d sc=%0d want %h %0d %0d", c, pc, redirect_cnt, stall_cnt, m_pc, m_rc, m_sc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_load_use();
    test_halt();
    test_fault();
    test_wrap();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
